// File: rtl/frame_transfer_fifo.sv
// frame_transfer_fifo
//   Elastic buffer for the frame transfer bus. Source beats (type, pixel, end
//   flag) are stored in a DEPTH-entry first-word-fall-through FIFO and presented
//   on the destination side with valid/ready backpressure. It also tracks how
//   many complete macroblocks are held.
//
//   Optional feature macro: FRAME_TRANSFER_FIFO_STATS_EN
//     defined     : ul32BeatCount / ul32MacroBlockCount count delivered beats and
//                   macroblocks, saturating, cleared only by ul1Reset.
//     not defined : both statistics outputs are tied to 0.
//
// Ports
//   ul1Clock, ul1Reset                  clock, synchronous active-high reset
//   ul1InActive/ulInMacroBlockType/
//   ulInPixelData/ul1InMacroBlockEnd    source beat
//   ul1InReady, ul1InAlmostFull         source backpressure / occupancy warning
//   ul1OutReset_n                       registered reset forwarded to destination
//   ul1OutActive/ulOutMacroBlockType/
//   ulOutPixelData/ul1OutMacroBlockEnd  destination beat (head entry)
//   ul1OutReady                         destination backpressure
//   ul1MacroBlockAvail                  at least one complete macroblock held
//   ul32BeatCount, ul32MacroBlockCount  delivery statistics
module frame_transfer_fifo #(
  parameter int unsigned PIXEL_WIDTH  = 24,
  parameter int unsigned MBTYPE_WIDTH = 4,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_LEVEL  = 12
) (
  input  logic                    ul1Clock,
  input  logic                    ul1Reset,
  input  logic                    ul1InActive,
  input  logic [MBTYPE_WIDTH-1:0] ulInMacroBlockType,
  input  logic [PIXEL_WIDTH-1:0]  ulInPixelData,
  input  logic                    ul1InMacroBlockEnd,
  output logic                    ul1InReady,
  output logic                    ul1InAlmostFull,
  output logic                    ul1OutReset_n,
  output logic                    ul1OutActive,
  output logic [MBTYPE_WIDTH-1:0] ulOutMacroBlockType,
  output logic [PIXEL_WIDTH-1:0]  ulOutPixelData,
  output logic                    ul1OutMacroBlockEnd,
  input  logic                    ul1OutReady,
  output logic                    ul1MacroBlockAvail,
  output logic [31:0]             ul32BeatCount,
  output logic [31:0]             ul32MacroBlockCount
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [MBTYPE_WIDTH-1:0] mb_type;
    logic [PIXEL_WIDTH-1:0]  pixel;
    logic                    mb_end;
  } beat_t;

  beat_t           mem [DEPTH];
  beat_t           in_beat;
  beat_t           out_beat;
  beat_t           head_next;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_ptr_next;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   occ_next;
  logic [CW-1:0]   mb_cnt;
  logic [CW-1:0]   mb_cnt_next;
  logic            push;
  logic            pop;

  assign in_beat = '{mb_type: ulInMacroBlockType, pixel: ulInPixelData, mb_end: ul1InMacroBlockEnd};
  assign push    = ul1InActive & ul1InReady;
  assign pop     = ul1OutActive & ul1OutReady;

  // Next occupancy, macroblock count and the entry that will be at the head.
  always_comb begin
    occ_next    = occ;
    mb_cnt_next = mb_cnt;
    rd_ptr_next = rd_ptr;
    head_next   = '0;

    case ({push, pop})
      2'b10:   occ_next = occ + CW'(1);
      2'b01:   occ_next = occ - CW'(1);
      default: occ_next = occ;
    endcase

    case ({push & ul1InMacroBlockEnd, pop & ul1OutMacroBlockEnd})
      2'b10:   mb_cnt_next = mb_cnt + CW'(1);
      2'b01:   mb_cnt_next = mb_cnt - CW'(1);
      default: mb_cnt_next = mb_cnt;
    endcase

    if (pop) begin
      rd_ptr_next = rd_ptr + AW'(1);
    end

    // The incoming beat lands on the new head slot only when it is the sole entry.
    if (occ_next != '0) begin
      if (push && (wr_ptr == rd_ptr_next)) begin
        head_next = in_beat;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end
  end

  // Storage array; not reset, entries are only read once written.
  always_ff @(posedge ul1Clock) begin
    if (push) begin
      mem[wr_ptr] <= in_beat;
    end
  end

  // Pointers, counters and registered outputs.
  always_ff @(posedge ul1Clock) begin
    if (ul1Reset) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      occ                <= '0;
      mb_cnt             <= '0;
      out_beat           <= '0;
      ul1InReady         <= 1'b0;
      ul1InAlmostFull    <= 1'b0;
      ul1OutActive       <= 1'b0;
      ul1MacroBlockAvail <= 1'b0;
      ul1OutReset_n      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr             <= rd_ptr_next;
      occ                <= occ_next;
      mb_cnt             <= mb_cnt_next;
      out_beat           <= head_next;
      ul1InReady         <= (occ_next != CW'(DEPTH));
      ul1InAlmostFull    <= (occ_next >= CW'(AFULL_LEVEL));
      ul1OutActive       <= (occ_next != '0);
      ul1MacroBlockAvail <= (mb_cnt_next != '0);
      ul1OutReset_n      <= 1'b1;
    end
  end

  assign ulOutMacroBlockType = out_beat.mb_type;
  assign ulOutPixelData      = out_beat.pixel;
  assign ul1OutMacroBlockEnd = out_beat.mb_end;

`ifdef FRAME_TRANSFER_FIFO_STATS_EN
  logic [31:0] beat_cnt;
  logic [31:0] mb_done_cnt;

  // Saturating delivery statistics.
  always_ff @(posedge ul1Clock) begin
    if (ul1Reset) begin
      beat_cnt    <= '0;
      mb_done_cnt <= '0;
    end else if (pop) begin
      if (beat_cnt != '1) begin
        beat_cnt <= beat_cnt + 32'd1;
      end
      if (ul1OutMacroBlockEnd && (mb_done_cnt != '1)) begin
        mb_done_cnt <= mb_done_cnt + 32'd1;
      end
    end
  end

  assign ul32BeatCount       = beat_cnt;
  assign ul32MacroBlockCount = mb_done_cnt;
`else
  assign ul32BeatCount       = '0;
  assign ul32MacroBlockCount = '0;
`endif

endmodule

// File: tb/tb_frame_transfer_fifo.sv
// tb_frame_transfer_fifo
//   Directed bench for frame_transfer_fifo with a queue scoreboard: beats are
//   pushed to the queue when accepted and compared at the DUT head every cycle.
module tb_frame_transfer_fifo;

  localparam int unsigned PW    = 24;
  localparam int unsigned TW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFL   = 12;

  typedef struct packed {
    logic [TW-1:0] t;
    logic [PW-1:0] d;
    logic          e;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_active = 1'b0;
  logic [TW-1:0] in_type = '0;
  logic [PW-1:0] in_data = '0;
  logic          in_end = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, in_afull, out_reset_n, out_active, out_end, mb_avail;
  logic [TW-1:0] out_type;
  logic [PW-1:0] out_data;
  logic [31:0]   beat_count, mb_count;

  frame_transfer_fifo #(
    .PIXEL_WIDTH(PW), .MBTYPE_WIDTH(TW), .DEPTH(DEPTH), .AFULL_LEVEL(AFL)
  ) dut (
    .ul1Clock(clk),
    .ul1Reset(rst),
    .ul1InActive(in_active),
    .ulInMacroBlockType(in_type),
    .ulInPixelData(in_data),
    .ul1InMacroBlockEnd(in_end),
    .ul1InReady(in_ready),
    .ul1InAlmostFull(in_afull),
    .ul1OutReset_n(out_reset_n),
    .ul1OutActive(out_active),
    .ulOutMacroBlockType(out_type),
    .ulOutPixelData(out_data),
    .ul1OutMacroBlockEnd(out_end),
    .ul1OutReady(out_ready),
    .ul1MacroBlockAvail(mb_avail),
    .ul32BeatCount(beat_count),
    .ul32MacroBlockCount(mb_count)
  );

  always #5 clk = ~clk;

  beat_t       sb[$];
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;
  logic        rst_q  = 1'b1;
  int unsigned beats_m = 0;
  int unsigned mbs_m   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mb_in_q();
    int n = 0;
    foreach (sb[i]) if (sb[i].e) n++;
    return n;
  endfunction

  function automatic logic [31:0] exp_beats();
`ifdef FRAME_TRANSFER_FIFO_STATS_EN
    return beats_m;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_mbs();
`ifdef FRAME_TRANSFER_FIFO_STATS_EN
    return mbs_m;
`else
    return 32'd0;
`endif
  endfunction

  // Compare all outputs against the model just after a clock edge.
  task automatic post_check();
    beat_t h;
    if (rst_q) begin
      chk("rst_out_reset_n", 32'(out_reset_n), 32'd0);
      chk("rst_in_ready",    32'(in_ready),    32'd0);
      chk("rst_out_active",  32'(out_active),  32'd0);
      chk("rst_afull",       32'(in_afull),    32'd0);
      chk("rst_avail",       32'(mb_avail),    32'd0);
      chk("rst_data",        32'(out_data),    32'd0);
      chk("rst_type",        32'(out_type),    32'd0);
      chk("rst_end",         32'(out_end),     32'd0);
    end else begin
      chk("out_reset_n", 32'(out_reset_n), 32'd1);
      chk("in_ready",    32'(in_ready),    32'(sb.size() != DEPTH));
      chk("out_active",  32'(out_active),  32'(sb.size() != 0));
      chk("afull",       32'(in_afull),    32'(sb.size() >= AFL));
      chk("avail",       32'(mb_avail),    32'(mb_in_q() != 0));
      if (sb.size() != 0) begin
        h = sb[0];
        chk("head_data", 32'(out_data), 32'(h.d));
        chk("head_type", 32'(out_type), 32'(h.t));
        chk("head_end",  32'(out_end),  32'(h.e));
      end
    end
    chk("beat_count", beat_count, exp_beats());
    chk("mb_count",   mb_count,   exp_mbs());
  endtask

  // Apply the current inputs for one cycle, updating the scoreboard.
  task automatic tick();
    bit    rdy;
    bit    do_push;
    bit    do_pop;
    beat_t h;
    rdy     = !rst_q && (sb.size() < DEPTH);
    do_push = in_active && rdy;
    do_pop  = out_ready && !rst_q && (sb.size() > 0);
    if (do_pop) begin
      h = sb.pop_front();
      beats_m++;
      if (h.e) mbs_m++;
    end
    if (do_push) sb.push_back('{t: in_type, d: in_data, e: in_end});
    if (rst) begin
      sb.delete();
      beats_m = 0;
      mbs_m   = 0;
    end
    rst_q = rst;
    @(posedge clk);
    #1;
    post_check();
  endtask

  initial begin
    // Reset for three cycles, then release.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Single end beat held under backpressure, then delivered.
    out_ready = 1'b0;
    in_active = 1'b1; in_data = 24'hA5A5A5; in_type = 4'd2; in_end = 1'b1;
    tick();
    in_active = 1'b0;
    chk("single_data", 32'(out_data), 32'h00A5A5A5);
    chk("single_avail", 32'(mb_avail), 32'd1);
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_drained", 32'(out_active), 32'd0);
    tick();

    // Fill to full, offer a 17th beat, then drain in order.
    in_end = 1'b0; in_type = 4'd5;
    for (int i = 0; i < 17; i++) begin
      in_data = PW'(i);
      in_active = 1'b1;
      tick();
    end
    in_active = 1'b0;
    chk("full_not_ready", 32'(in_ready), 32'd0);
    chk("full_afull", 32'(in_afull), 32'd1);
    out_ready = 1'b1;
    repeat (17) tick();
    out_ready = 1'b0;
    chk("drained_empty", 32'(out_active), 32'd0);

    // Hold occupancy at 8 with continuous push and pop; pointers wrap.
    for (int i = 0; i < 8; i++) begin
      in_data = PW'(24'h100 + i); in_type = TW'(i); in_active = 1'b1;
      tick();
    end
    out_ready = 1'b1;
    for (int i = 8; i < 72; i++) begin
      in_data = PW'(24'h100 + i); in_type = TW'(i); in_end = i[2];
      tick();
    end
    in_active = 1'b0; in_end = 1'b0;
    repeat (9) tick();
    out_ready = 1'b0;

    // Four-beat macroblock, end on the last beat only.
    for (int i = 0; i < 4; i++) begin
      in_data = PW'(24'h200 + i); in_type = 4'd3; in_end = (i == 3);
      in_active = 1'b1;
      tick();
    end
    in_active = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    // Pop the end beat while pushing another end beat: availability holds.
    in_data = 24'h2FF; in_end = 1'b1; in_active = 1'b1;
    tick();
    in_active = 1'b0;
    chk("mb_swap_avail", 32'(mb_avail), 32'd1);
    repeat (2) tick();
    out_ready = 1'b0;

    // Statistics: 10 beats / 3 macroblocks after a fresh reset.
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    for (int i = 0; i < 10; i++) begin
      in_data = PW'(24'h300 + i); in_type = 4'd7;
      in_end = (i == 2) || (i == 5) || (i == 9);
      in_active = 1'b1;
      tick();
    end
    in_active = 1'b0; in_end = 1'b0;
    out_ready = 1'b1;
    repeat (11) tick();
    out_ready = 1'b0;
`ifdef FRAME_TRANSFER_FIFO_STATS_EN
    chk("stats_beats", beat_count, 32'd10);
    chk("stats_mbs",   mb_count,   32'd3);
`else
    chk("stats_beats_off", beat_count, 32'd0);
    chk("stats_mbs_off",   mb_count,   32'd0);
`endif

    // Reset with five beats stored discards everything.
    for (int i = 0; i < 5; i++) begin
      in_data = PW'(24'h400 + i); in_active = 1'b1;
      tick();
    end
    in_active = 1'b0;
    rst = 1'b1; tick();
    chk("midrst_active", 32'(out_active), 32'd0);
    rst = 1'b0; tick();
    chk("midrst_empty", 32'(out_active), 32'd0);
    chk("midrst_beats", beat_count, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
